// File: rtl/and_unit_arbiter_pkg.sv
// Shared types and helpers for the round-robin AND-unit arbiter.
package and_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Id width never drops below 1 so a single requester still has a real port.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/and_unit_arbiter_if.sv
// Requester/response bundle between operand producers and the AND-unit arbiter.
interface and_unit_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) ();
    localparam int IDW = and_arb_pkg::id_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic [CNT_W-1:0]      ops_done;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, ops_done
    );

endinterface

// File: rtl/and_unit_arbiter_and_unit.sv
// The single shared AND datapath; purely combinational.
module and_unit #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] c_o
);
    assign c_o = a_i & b_i;
endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one AND unit among NREQ requesters, with a
// one-entry response slot and a completed-operation counter.
module and_unit_arbiter
    import and_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    and_unit_arbiter_if.slave bus
);
    localparam int IDW = id_width(NREQ);

    slot_state_e      state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d, win_id;
    logic [WIDTH-1:0] data_q, data_d, a_sel, b_sel, and_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  ready;
    logic             win_vld, can_accept, rsp_vld, xfer, drain;
    int               scan;

    // Scan from ptr upward with wrap; first valid requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        scan    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan = int'(ptr_q) + k;
            if (scan >= NREQ) scan = scan - NREQ;
            if (!win_vld && bus.req_valid[IDW'(scan)]) begin
                win_vld = 1'b1;
                win_id  = IDW'(scan);
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                a_sel    = bus.req_a[i*WIDTH +: WIDTH];
                b_sel    = bus.req_b[i*WIDTH +: WIDTH];
                ready[i] = can_accept & win_vld;
            end
        end
    end

    and_unit #(.WIDTH(WIDTH)) u_and (
        .a_i (a_sel),
        .b_i (b_sel),
        .c_o (and_c)
    );

    // Slot FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Slot FSM: next state
    always_comb begin
        state_d = state_q;
        if (xfer)                                state_d = FULL;
        else if (state_q == FULL && bus.rsp_ready) state_d = EMPTY;
    end

    // Slot FSM: outputs. rst_n gating keeps req_ready low throughout reset.
    always_comb begin
        rsp_vld    = (state_q == FULL);
        can_accept = rst_n & (~rsp_vld | bus.rsp_ready);
        drain      = rsp_vld & bus.rsp_ready;
    end

    assign xfer   = can_accept & win_vld;
    assign data_d = xfer ? and_c  : data_q;
    assign id_d   = xfer ? win_id : id_q;
    assign ptr_d  = !xfer ? ptr_q :
                    (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
    assign cnt_d  = cnt_q + CNT_W'(drain);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.ops_done  = cnt_q;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed and random checks of and_unit_arbiter against a behavioural model.
module tb_and_unit_arbiter;
    localparam int NREQ   = 4;
    localparam int WIDTH  = 4;
    localparam int CNT_W  = 16;
    localparam int CNT_W2 = 2;

    typedef logic [NREQ*WIDTH-1:0] opv_t;
    typedef logic [NREQ-1:0]       vld_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vld_t req_valid = '0;
    opv_t req_a = '0, req_b = '0;
    logic rsp_ready = 1'b0;

    and_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W))  bus0 ();
    and_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W2)) bus1 ();

    assign bus0.req_valid = req_valid;
    assign bus0.req_a     = req_a;
    assign bus0.req_b     = req_b;
    assign bus0.rsp_ready = rsp_ready;
    assign bus1.req_valid = req_valid;
    assign bus1.req_a     = req_a;
    assign bus1.req_b     = req_b;
    assign bus1.rsp_ready = rsp_ready;

    and_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    and_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int checks = 0;
    int failures = 0;

    // Reference: slot contents, rr pointer and completion count as plain integers.
    int               m_ptr, m_id, m_cnt;
    bit               m_vld;
    logic [WIDTH-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_id = 0; m_cnt = 0; m_vld = 0; m_data = '0;
    endtask

    task automatic step(input vld_t v, input opv_t a, input opv_t b, input logic rr);
        int   win;
        bit   can;
        vld_t exp_rdy;
        req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
        #1;
        win = -1;
        for (int k = 0; k < NREQ; k++)
            if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        can = !m_vld || rr;
        exp_rdy = '0;
        if (can && win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready",    32'(bus0.req_ready), 32'(exp_rdy));
        chk("req_ready_c2", 32'(bus1.req_ready), 32'(exp_rdy));
        chk("rsp_valid",    32'(bus0.rsp_valid), 32'(m_vld));
        chk("rsp_data",     32'(bus0.rsp_data),  32'(m_data));
        chk("rsp_id",       32'(bus0.rsp_id),    32'(m_id));
        chk("ops_done",     32'(bus0.ops_done),  32'(m_cnt % 65536));
        chk("ops_done_c2",  32'(bus1.ops_done),  32'(m_cnt % 4));
        @(posedge clk);
        if (m_vld && rr) m_cnt++;
        if (can && win >= 0) begin
            m_data = a[win*WIDTH +: WIDTH] & b[win*WIDTH +: WIDTH];
            m_id   = win;
            m_vld  = 1;
            m_ptr  = (win + 1) % NREQ;
        end else if (rr) begin
            m_vld = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        req_valid = 4'b1111;
        @(negedge clk);
        chk("reset_ready", 32'(bus0.req_ready), 32'h0);
        chk("reset_valid", 32'(bus0.rsp_valid), 32'h0);
        chk("reset_ops",   32'(bus0.ops_done),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, a=C, b=A
        step(4'b0001, opv_t'(16'h000C), opv_t'(16'h000A), 1'b1);
        chk("single_valid", 32'(bus0.rsp_valid), 32'h1);
        chk("single_data",  32'(bus0.rsp_data),  32'h8);
        chk("single_id",    32'(bus0.rsp_id),    32'h0);

        // Asynchronous reset while the slot is full
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus0.rsp_valid), 32'h0);
        chk("midrst_data",  32'(bus0.rsp_data),  32'h0);
        chk("midrst_id",    32'(bus0.rsp_id),    32'h0);
        chk("midrst_ready", 32'(bus0.req_ready), 32'h0);
        chk("midrst_ops",   32'(bus0.ops_done),  32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters valid: rotation 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, opv_t'($urandom), opv_t'($urandom), 1'b1);
            chk("rr_id", 32'(bus0.rsp_id), 32'(k % 4));
            if (k == 5) chk("cnt2_wrap", 32'(bus1.ops_done), 32'h1);
        end
        step(4'b0000, '0, '0, 1'b1);
        chk("rr_ops",    32'(bus0.ops_done), 32'd8);
        chk("rr_ops_c2", 32'(bus1.ops_done), 32'd0);

        // Backpressure then release with no bubble
        step(4'b1111, opv_t'($urandom), opv_t'($urandom), 1'b1);
        for (int k = 0; k < 3; k++)
            step(4'b1111, opv_t'($urandom), opv_t'($urandom), 1'b0);
        for (int k = 0; k < 3; k++)
            step(4'b1111, opv_t'($urandom), opv_t'($urandom), 1'b1);

        // Pointer wrap: park ptr at 3, then 1001 grants 3 then 0
        do_reset();
        step(4'b0100, opv_t'($urandom), opv_t'($urandom), 1'b1);
        step(4'b1001, opv_t'($urandom), opv_t'($urandom), 1'b1);
        chk("wrap_id3", 32'(bus0.rsp_id), 32'h3);
        step(4'b1001, opv_t'($urandom), opv_t'($urandom), 1'b1);
        chk("wrap_id0", 32'(bus0.rsp_id), 32'h0);

        // Random traffic with random backpressure
        for (int n = 0; n < 300; n++)
            step(vld_t'($urandom_range(0, 15)), opv_t'($urandom), opv_t'($urandom),
                 ($urandom_range(0, 3) != 0));
        step(4'b0000, '0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
